// File: rtl/nios_loader_pkg.sv
// Shared types and constants for the on-chip memory boot loader.
package nios_loader_pkg;

    localparam int DEPTH_DEF      = 2048;
    localparam int ADDR_W_DEF     = 11;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/nios_loader_byte_packer.sv
// Little-endian byte-to-word packer: byte lane register, lane index and word-full flag.
module nios_loader_byte_packer
    import nios_loader_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clr_i,
    input  logic                          en_i,
    input  logic [7:0]                    data_i,
    output logic [8*BYTES_PER_WORD-1:0]   word_o,
    output logic                          full_o
);

    logic [IDX_W-1:0]            idx_q;
    logic [8*BYTES_PER_WORD-1:0] word_q;

    // Asserted in the cycle the last lane of the word is being accepted.
    assign full_o = en_i && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    assign word_o = word_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (clr_i) begin
            idx_q  <= '0;
        end else if (en_i) begin
            word_q[{idx_q, 3'b000} +: 8] <= data_i;
            idx_q                        <= idx_q + 1'b1;
        end
    end

endmodule

// File: rtl/nios_onchip_mem_loader.sv
// Boot-image loader: packs a byte stream into words and writes them from address 0.
// Optional macro LOADER_CHECKSUM_EN enables the additive checksum of written words.
module nios_onchip_mem_loader
    import nios_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [11:0]       length,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [31:0]       writedata,
    output logic              clken,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum
);

    localparam logic [12:0] DEPTH_L = 13'(DEPTH);

    state_e            state_q;
    logic [ADDR_W:0]   wcnt_q, wcnt_d, len_q;
    logic [ADDR_W-1:0] addr_q;
    logic              s_ready_q, busy_q, wr_q, done_q, err_q;
    logic [31:0]       word;
    logic              accept, word_full, load_ok, clr;

    assign accept  = s_valid & s_ready_q;
    assign load_ok = (length != '0) && ({1'b0, length} <= DEPTH_L);
    assign clr     = start && (state_q == ST_IDLE || state_q == ST_DONE) && load_ok;
    assign wcnt_d  = wcnt_q + 1'b1;

    nios_loader_byte_packer u_packer (
        .clk_i  (clk),
        .rst_i  (reset),
        .clr_i  (clr),
        .en_i   (accept),
        .data_i (s_data),
        .word_o (word),
        .full_o (word_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        done_q <= 1'b0;
                        if (load_ok) begin
                            len_q     <= length[ADDR_W:0];
                            wcnt_q    <= '0;
                            err_q     <= 1'b0;
                            s_ready_q <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= ST_FILL;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_FILL: begin
                    if (word_full) begin
                        s_ready_q <= 1'b0;
                        wr_q      <= 1'b1;
                        addr_q    <= wcnt_q[ADDR_W-1:0];
                        state_q   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    wr_q   <= 1'b0;
                    wcnt_q <= wcnt_d;
                    // Counter is one bit wider than the address so a full-depth load terminates.
                    if (wcnt_d == len_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        s_ready_q <= 1'b1;
                        state_q   <= ST_FILL;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (clr) begin
            sum_q <= '0;
        end else if (state_q == ST_WRITE) begin
            sum_q <= sum_q + word;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    assign s_ready    = s_ready_q;
    assign address    = addr_q;
    assign byteenable = {4{wr_q}};
    assign chipselect = wr_q;
    assign write      = wr_q;
    assign writedata  = word;
    assign clken      = 1'b1;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = err_q;

endmodule

// File: doc/nios_onchip_mem_loader.md
# nios_onchip_mem_loader

Boot-image loader placed directly upstream of the on-chip program memory's write port. It accepts a byte stream (valid/ready), packs bytes little-endian into 32-bit words and issues single-cycle Avalon-style writes at consecutive word addresses starting from 0. The host holds the Nios core in reset until `done` rises, so the loader is the only writer to the memory during load.

## Interface
- `DEPTH`, 2048: memory depth in 32-bit words.
- `ADDR_W`, 11: word-address width; must equal log2(`DEPTH`).
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; samples `length` and begins a load.
- `length` in 12: number of words to load; valid range 1..`DEPTH`.
- `s_data` in 8: stream byte.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: loader accepts a byte this cycle.
- `address` out `ADDR_W`: memory word address.
- `byteenable` out 4: byte lanes written.
- `chipselect` out 1: memory select.
- `write` out 1: memory write strobe.
- `writedata` out 32: packed word.
- `clken` out 1: memory clock enable.
- `busy` out 1: a load is in progress.
- `done` out 1: sticky; the last load completed.
- `error` out 1: sticky; the last `start` carried an illegal `length`.
- `checksum` out 32: additive checksum of the written words (see Configuration).

## Operation
- States: IDLE, FILL, WRITE, DONE.
- IDLE:
  - On `start`, if `length` is 0 or greater than `DEPTH`: set `error`, go to DONE, perform no writes.
  - Otherwise latch `length`, clear the word counter, byte index, `done`, `error` and checksum, and go to FILL.
- FILL:
  - `s_ready`=1.
  - Each `s_valid & s_ready` stores `s_data` into byte lane `idx` (byte 0 goes to bits 7:0) and increments `idx`.
  - Accepting the fourth byte (`idx`=3) moves to WRITE.
- WRITE: drive the following for exactly one cycle, then:
  - Outputs: `chipselect`=1, `write`=1, `byteenable`=4'hF, `address`=word counter, `writedata`=packed word.
  - Increment the word counter.
  - If the count after the increment equals the latched length, go to DONE. Otherwise go to FILL with `idx`=0.
- DONE:
  - `done`=1 when there was no error.
  - `start` re-runs the IDLE checks and starts a new load; the sticky flags are cleared at that point.
- `start` while in FILL or WRITE is ignored.
- `busy` = state is FILL or WRITE.
- `clken` is constant 1 at all times, including during reset.
- `chipselect`, `write` and `byteenable` are 0 in every state except WRITE.
- Word counter is `ADDR_W`+1 bits wide, so `length`=`DEPTH` finishes at address `DEPTH`-1 with no wrap.
- Bytes presented while `s_ready`=0 are not consumed; upstream holds them.

## Timing
- Reset values:
  - `s_ready`, `address`, `byteenable`, `chipselect`, `write`, `writedata`, `busy`, `done`, `error` and `checksum` are all 0.
  - `clken` is 1.
  - State is IDLE.
- `start` at cycle N: `busy`=1 and `s_ready`=1 from cycle N+1.
- Four bytes on back-to-back cycles give the write strobe in the next cycle, so sustained throughput is 1 word per 5 cycles.
- Last WRITE at cycle M: `done`=1 and `busy`=0 at M+1.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-load returns immediately to the reset values. Memory contents already written are left as is.
- Illegal `start` at cycle N: `error`=1 at N+1, with no strobe ever asserted.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - `checksum` accumulates the modulo-2^32 sum of every written word, updated in the WRITE cycle.
  - The value is final when `done` rises and is cleared on a legal `start`.
- Not defined: `checksum` is tied to 0 and no accumulator is synthesized. The port stays present so the interface is stable.

## Structure
- Package `nios_loader_pkg` holds:
  - the state enum (IDLE/FILL/WRITE/DONE);
  - the `DEPTH` and `ADDR_W` defaults;
  - the `BYTES_PER_WORD`=4 constant.
- Sub-module `nios_loader_byte_packer` holds the byte-lane register, the `idx` counter and the word-full flag. The FSM, address counter and checksum stay in the top module.

## Test plan
- Reset release followed by an idle period: all outputs stay at their reset values, `clken`=1, and the strobes are never asserted.
- `start` with `length`=2, stream bytes 01..08 back-to-back:
  - writes 32'h04030201 at address 0, then 32'h08070605 at address 1;
  - `done` rises the cycle after the second write;
  - `checksum` = 32'h0C0A0806 with the macro, 0 without it.
- Same load with `s_valid` toggling every other cycle: identical writes, with each write strobe 8 cycles apart.
- `start` with `length`=0 and with `length`=2049: `error`=1, no write strobe.
- `length`=2048 with random bytes: the last write is at address 2047, with no write to address 0 after the first.
- `reset` asserted after the 6th byte of a 2-word load:
  - only address 0 has been written;
  - outputs return to reset values;
  - a new `start` loads correctly from address 0.
